// File: rtl/memctl_cfg_seq.sv
// Boot-time configuration sequencer: owns the AHB-Lite bus after reset, programs the SDRAM
// controller registers, then hands the bus to the CPU. Optional SCTLR polling: MEMCTL_CFG_POLL_EN.
module memctl_cfg_seq #(
    parameter logic [31:0] CFG_BASE   = 32'h2000_0000,
    parameter logic [31:0] SCONR_VAL  = 32'h0000_1A48,
    parameter logic [31:0] STMG0R_VAL = 32'h0226_6C4A,
    parameter logic [31:0] STMG1R_VAL = 32'h0007_0008,
    parameter logic [31:0] SREFR_VAL  = 32'h0000_0410,
    parameter logic [31:0] SCTLR_VAL  = 32'h0000_3089,
    parameter logic [15:0] POLL_MAX   = 16'd1023
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] cpu_haddr,
    input  logic [1:0]  cpu_htrans,
    input  logic        cpu_hwrite,
    input  logic [2:0]  cpu_hsize,
    input  logic [31:0] cpu_hwdata,
    output logic        cpu_hready,
    output logic [31:0] cpu_hrdata,
    output logic [31:0] m_haddr,
    output logic [1:0]  m_htrans,
    output logic        m_hwrite,
    output logic [2:0]  m_hsize,
    output logic [31:0] m_hwdata,
    output logic        m_hsel_reg,
    input  logic        m_hready,
    input  logic        m_hresp,
    input  logic [31:0] m_hrdata,
    output logic        init_done,
    output logic        init_err
);

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  LAST_IDX      = 3'd4;
    localparam logic [31:0] SCTLR_OFS     = 32'h0000_000C;

    typedef enum logic [2:0] {RST, WA, WD, RA, RD, PASS, ERR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

`ifdef MEMCTL_CFG_POLL_EN
    logic [15:0] poll_q, poll_d;
    logic [15:0] poll_inc;
`else
    logic        unused_poll_max;
    assign unused_poll_max = ^POLL_MAX;
`endif

    // SCTLR goes last so the initialise request only fires once timing is programmed.
    function automatic logic [31:0] wr_offset(input logic [2:0] idx);
        case (idx)
            3'd0:    wr_offset = 32'h0000_0000;
            3'd1:    wr_offset = 32'h0000_0004;
            3'd2:    wr_offset = 32'h0000_0008;
            3'd3:    wr_offset = 32'h0000_0010;
            default: wr_offset = SCTLR_OFS;
        endcase
    endfunction

    function automatic logic [31:0] wr_value(input logic [2:0] idx);
        case (idx)
            3'd0:    wr_value = SCONR_VAL;
            3'd1:    wr_value = STMG0R_VAL;
            3'd2:    wr_value = STMG1R_VAL;
            3'd3:    wr_value = SREFR_VAL;
            default: wr_value = SCTLR_VAL;
        endcase
    endfunction

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= RST;
            idx_q    <= 3'd0;
            hwdata_q <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MEMCTL_CFG_POLL_EN
            poll_q   <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hwdata_q <= hwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef MEMCTL_CFG_POLL_EN
            poll_q   <= poll_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hwdata_d = hwdata_q;
        done_d   = done_q;
        err_d    = err_q;
`ifdef MEMCTL_CFG_POLL_EN
        poll_d   = poll_q;
        poll_inc = poll_q + 16'd1;
`endif
        case (state_q)
            RST: begin
                if (m_hready) begin
                    state_d  = WA;
                    idx_d    = 3'd0;
                    hwdata_d = wr_value(3'd0);
                end
            end
            WA: begin
                if (m_hready) state_d = WD;
            end
            WD: begin
                if (m_hresp) begin
                    state_d = ERR;
                end else if (m_hready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef MEMCTL_CFG_POLL_EN
                        state_d = RA;
                        poll_d  = 16'd0;
`else
                        state_d = PASS;
`endif
                    end else begin
                        // Write data is loaded on WA entry so it is stable across the whole data phase.
                        state_d  = WA;
                        idx_d    = idx_q + 3'd1;
                        hwdata_d = wr_value(idx_q + 3'd1);
                    end
                end
            end
`ifdef MEMCTL_CFG_POLL_EN
            RA: begin
                if (m_hready) state_d = RD;
            end
            RD: begin
                if (m_hresp) begin
                    state_d = ERR;
                end else if (m_hready) begin
                    if (!m_hrdata[0]) begin
                        state_d = PASS;
                    end else begin
                        poll_d  = poll_inc;
                        state_d = (poll_inc >= POLL_MAX) ? ERR : RA;
                    end
                end
            end
`endif
            ERR:     state_d = PASS;
            default: state_d = state_q;
        endcase
        if (state_d == PASS || state_d == ERR) done_d = 1'b1;
        if (state_d == ERR) err_d = 1'b1;
    end

    always_comb begin
        m_htrans   = HTRANS_IDLE;
        m_haddr    = 32'h0;
        m_hwrite   = 1'b0;
        m_hsize    = HSIZE_WORD;
        m_hwdata   = hwdata_q;
        m_hsel_reg = 1'b0;
        cpu_hready = 1'b0;
        cpu_hrdata = 32'h0;
        case (state_q)
            WA: begin
                m_htrans   = HTRANS_NONSEQ;
                m_haddr    = CFG_BASE + wr_offset(idx_q);
                m_hwrite   = 1'b1;
                m_hsel_reg = 1'b1;
            end
            WD: begin
                m_haddr  = CFG_BASE + wr_offset(idx_q);
                m_hwrite = 1'b1;
            end
            RA: begin
                m_htrans   = HTRANS_NONSEQ;
                m_haddr    = CFG_BASE + SCTLR_OFS;
                m_hsel_reg = 1'b1;
            end
            RD: begin
                m_haddr = CFG_BASE + SCTLR_OFS;
            end
            PASS, ERR: begin
                // The CPU's held first address phase goes straight onto the bus.
                m_htrans   = cpu_htrans;
                m_haddr    = cpu_haddr;
                m_hwrite   = cpu_hwrite;
                m_hsize    = cpu_hsize;
                m_hwdata   = cpu_hwdata;
                cpu_hready = m_hready;
                cpu_hrdata = m_hrdata;
            end
            default: ;
        endcase
    end

    assign init_done = done_q;
    assign init_err  = err_q;

endmodule

// File: tb/tb_memctl_cfg_seq.sv
// Directed bench for memctl_cfg_seq: write order/data, wait states, error abort,
// mid-transfer reset, CPU pass-through, and SCTLR polling when MEMCTL_CFG_POLL_EN is defined.
module tb_memctl_cfg_seq;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [15:0] PM   = 16'd6;
`ifdef MEMCTL_CFG_POLL_EN
    localparam int POLL_CYC = 2;
`else
    localparam int POLL_CYC = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] cpu_haddr = 32'h0;
    logic [1:0]  cpu_htrans = 2'b00;
    logic        cpu_hwrite = 1'b0;
    logic [2:0]  cpu_hsize = 3'b010;
    logic [31:0] cpu_hwdata = 32'h0;
    logic        cpu_hready;
    logic [31:0] cpu_hrdata;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        m_hsel_reg;
    logic        m_hready = 1'b1;
    logic        m_hresp = 1'b0;
    logic [31:0] m_hrdata = 32'h0;
    logic        init_done;
    logic        init_err;

    always #5 HCLK = ~HCLK;

    memctl_cfg_seq #(.POLL_MAX(PM)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cpu_haddr(cpu_haddr), .cpu_htrans(cpu_htrans), .cpu_hwrite(cpu_hwrite),
        .cpu_hsize(cpu_hsize), .cpu_hwdata(cpu_hwdata),
        .cpu_hready(cpu_hready), .cpu_hrdata(cpu_hrdata),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hwdata(m_hwdata), .m_hsel_reg(m_hsel_reg),
        .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
        .init_done(init_done), .init_err(init_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_vec_t;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic        s_hready;
        logic [31:0] s_hrdata;
    } pt_vec_t;

    wr_vec_t wr_tab[5];
    pt_vec_t pt_tab[3];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        m_hready   = 1'b1;
        m_hresp    = 1'b0;
        m_hrdata   = 32'hDEAD_BEEF;
        cpu_haddr  = 32'h0;
        cpu_htrans = 2'b10;
        cpu_hwrite = 1'b0;
        cpu_hsize  = 3'b010;
        cpu_hwdata = 32'h0;
        tick();
        tick();
        HRESET = 1'b0;
        m_hrdata = 32'h0;
        cyc = 0;
        #1;
    endtask

    task automatic do_write(input int i, input int waits, input logic resp);
        chk($sformatf("wa%0d_htrans", i), {30'd0, m_htrans}, 32'd2);
        chk($sformatf("wa%0d_hsel", i), {31'd0, m_hsel_reg}, 32'd1);
        chk($sformatf("wa%0d_haddr", i), m_haddr, wr_tab[i].addr);
        chk($sformatf("wa%0d_hwrite", i), {31'd0, m_hwrite}, 32'd1);
        chk($sformatf("wa%0d_hsize", i), {29'd0, m_hsize}, 32'd2);
        chk($sformatf("wa%0d_cpu_hready", i), {31'd0, cpu_hready}, 32'd0);
        tick();
        for (int w = 0; w < waits; w++) begin
            m_hready = 1'b0;
            #1;
            chk($sformatf("wd%0d_wait%0d_hwdata", i, w), m_hwdata, wr_tab[i].data);
            chk($sformatf("wd%0d_wait%0d_htrans", i, w), {30'd0, m_htrans}, 32'd0);
            tick();
        end
        m_hready = 1'b1;
        m_hresp  = resp;
        #1;
        chk($sformatf("wd%0d_hwdata", i), m_hwdata, wr_tab[i].data);
        chk($sformatf("wd%0d_hsel", i), {31'd0, m_hsel_reg}, 32'd0);
        chk($sformatf("wd%0d_init_done", i), {31'd0, init_done}, 32'd0);
        tick();
        m_hresp = 1'b0;
    endtask

    task automatic run_writes(input int wait_idx, input int waits, input int err_idx);
        for (int i = 0; i < 5; i++) begin
            do_write(i, (i == wait_idx) ? waits : 0, (i == err_idx));
            if (i == err_idx) break;
        end
    endtask

`ifdef MEMCTL_CFG_POLL_EN
    task automatic poll_seq(input int n_ones, output int reads);
        reads = 0;
        for (int r = 0; r < 40; r++) begin
            if (!(m_htrans == 2'b10 && m_hsel_reg && m_haddr == BASE + 32'h0C)) break;
            chk("ra_hwrite", {31'd0, m_hwrite}, 32'd0);
            tick();
            m_hrdata = (reads < n_ones) ? 32'h0000_3089 : 32'h0000_3088;
            reads++;
            #1;
            chk("rd_htrans", {30'd0, m_htrans}, 32'd0);
            tick();
            m_hrdata = 32'h0;
        end
    endtask
`endif

    task automatic finish_seq(input int n_ones, output int reads);
        reads = 0;
`ifdef MEMCTL_CFG_POLL_EN
        poll_seq(n_ones, reads);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int reads;
        wr_tab[0] = '{32'h2000_0000, 32'h0000_1A48};
        wr_tab[1] = '{32'h2000_0004, 32'h0226_6C4A};
        wr_tab[2] = '{32'h2000_0008, 32'h0007_0008};
        wr_tab[3] = '{32'h2000_0010, 32'h0000_0410};
        wr_tab[4] = '{32'h2000_000C, 32'h0000_3089};
        pt_tab[0] = '{32'h0000_0000, 2'b10, 1'b0, 3'b010, 32'h0000_0000, 1'b1, 32'h1234_5678};
        pt_tab[1] = '{32'h2000_0010, 2'b11, 1'b1, 3'b001, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        pt_tab[2] = '{32'h8000_0004, 2'b00, 1'b1, 3'b000, 32'hA5A5_5A5A, 1'b1, 32'hFFFF_FFFF};

        // Zero-wait sequence, reset values first
        do_reset();
        m_hrdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_htrans", {30'd0, m_htrans}, 32'd0);
        chk("rst_haddr", m_haddr, 32'h0);
        chk("rst_hwdata", m_hwdata, 32'h0);
        chk("rst_hwrite", {31'd0, m_hwrite}, 32'd0);
        chk("rst_hsize", {29'd0, m_hsize}, 32'd2);
        chk("rst_hsel", {31'd0, m_hsel_reg}, 32'd0);
        chk("rst_cpu_hready", {31'd0, cpu_hready}, 32'd0);
        chk("rst_cpu_hrdata", cpu_hrdata, 32'h0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_init_err", {31'd0, init_err}, 32'd0);
        m_hrdata = 32'h0;
        tick();
        run_writes(-1, 0, -1);
        finish_seq(0, reads);
        chk("zw_done_cycle", cyc, 11 + POLL_CYC);
        chk("zw_init_done", {31'd0, init_done}, 32'd1);
        chk("zw_init_err", {31'd0, init_err}, 32'd0);

        for (int v = 0; v < 3; v++) begin
            cpu_haddr  = pt_tab[v].haddr;
            cpu_htrans = pt_tab[v].htrans;
            cpu_hwrite = pt_tab[v].hwrite;
            cpu_hsize  = pt_tab[v].hsize;
            cpu_hwdata = pt_tab[v].hwdata;
            m_hready   = pt_tab[v].s_hready;
            m_hrdata   = pt_tab[v].s_hrdata;
            #1;
            chk($sformatf("pt%0d_haddr", v), m_haddr, pt_tab[v].haddr);
            chk($sformatf("pt%0d_htrans", v), {30'd0, m_htrans}, {30'd0, pt_tab[v].htrans});
            chk($sformatf("pt%0d_hwrite", v), {31'd0, m_hwrite}, {31'd0, pt_tab[v].hwrite});
            chk($sformatf("pt%0d_hsize", v), {29'd0, m_hsize}, {29'd0, pt_tab[v].hsize});
            chk($sformatf("pt%0d_hwdata", v), m_hwdata, pt_tab[v].hwdata);
            chk($sformatf("pt%0d_hsel", v), {31'd0, m_hsel_reg}, 32'd0);
            chk($sformatf("pt%0d_cpu_hready", v), {31'd0, cpu_hready}, {31'd0, pt_tab[v].s_hready});
            chk($sformatf("pt%0d_cpu_hrdata", v), cpu_hrdata, pt_tab[v].s_hrdata);
            tick();
        end

        // Three wait states on write index 2
        do_reset();
        tick();
        run_writes(2, 3, -1);
        finish_seq(0, reads);
        chk("ws_done_cycle", cyc, 14 + POLL_CYC);
        chk("ws_init_done", {31'd0, init_done}, 32'd1);

        // Error response on write index 1
        do_reset();
        tick();
        run_writes(-1, 0, 1);
        chk("er_cycle", cyc, 5);
        chk("er_init_err", {31'd0, init_err}, 32'd1);
        chk("er_init_done", {31'd0, init_done}, 32'd1);
        chk("er_fetch_haddr", m_haddr, 32'h0);
        chk("er_fetch_htrans", {30'd0, m_htrans}, 32'd2);
        chk("er_hsel", {31'd0, m_hsel_reg}, 32'd0);
        chk("er_cpu_hready", {31'd0, cpu_hready}, 32'd1);
        tick();
        chk("er_pass_haddr", m_haddr, 32'h0);
        chk("er_pass_init_err", {31'd0, init_err}, 32'd1);

        // Reset during write index 3's data phase
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) do_write(i, 0, 1'b0);
        chk("mr_wa3_haddr", m_haddr, wr_tab[3].addr);
        tick();
        m_hready = 1'b0;
        HRESET = 1'b1;
        tick();
        chk("mr_htrans", {30'd0, m_htrans}, 32'd0);
        chk("mr_haddr", m_haddr, 32'h0);
        chk("mr_hwdata", m_hwdata, 32'h0);
        chk("mr_hsel", {31'd0, m_hsel_reg}, 32'd0);
        HRESET = 1'b0;
        m_hready = 1'b1;
        tick();
        chk("mr_restart_haddr", m_haddr, BASE);
        chk("mr_restart_htrans", {30'd0, m_htrans}, 32'd2);
        chk("mr_restart_hwdata", m_hwdata, wr_tab[0].data);

`ifdef MEMCTL_CFG_POLL_EN
        // Busy for five reads, then ready
        do_reset();
        tick();
        run_writes(-1, 0, -1);
        poll_seq(5, reads);
        chk("pl_reads", reads, 6);
        chk("pl_init_done", {31'd0, init_done}, 32'd1);
        chk("pl_init_err", {31'd0, init_err}, 32'd0);

        // Busy bit stuck: timeout after POLL_MAX reads
        do_reset();
        tick();
        run_writes(-1, 0, -1);
        poll_seq(1000, reads);
        chk("pt_reads", reads, {16'd0, PM});
        chk("pt_init_err", {31'd0, init_err}, 32'd1);
        chk("pt_init_done", {31'd0, init_done}, 32'd1);
        chk("pt_fetch_htrans", {30'd0, m_htrans}, 32'd2);
        chk("pt_fetch_hsel", {31'd0, m_hsel_reg}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
